// File: rtl/trig_event_monitor.sv
// trig_event_monitor: logs each rising edge of trig_in as a {timestamp, sequence} record in a small FIFO.
// Optional macro TRIG_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module trig_event_monitor #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             trig_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] ev_idx,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow,
  output logic             active
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] seq;
  logic             trig_d;
  logic             det_in;
  logic             trig_edge;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [TS_W-1:0]  mem_ts  [DEPTH];
  logic [CNT_W-1:0] mem_idx [DEPTH];

`ifdef TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], trig_in};
  end

  assign det_in = sync_q[1];
`else
  assign det_in = trig_in;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign trig_edge = det_in & ~trig_d;
  assign push_req  = trig_edge & en & ~clr;
  assign pop       = ~empty & ev_ready & ~clr;
  assign push      = push_req & (~full | pop);

  assign ev_valid = ~empty;
  assign ev_ts    = mem_ts[rd_ptr[AW-1:0]];
  assign ev_idx   = mem_idx[rd_ptr[AW-1:0]];
  assign active   = trig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts       <= '0;
      seq      <= '0;
      trig_d   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ts[i]  <= '0;
        mem_idx[i] <= '0;
      end
    end else begin
      ts     <= ts + TS_W'(1);
      trig_d <= det_in;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        seq      <= '0;
        ev_count <= '0;
        overflow <= 1'b0;
      end else begin
        // Sequence and count advance even when the record itself is dropped.
        if (push_req) begin
          seq <= seq + CNT_W'(1);
          if (ev_count != '1) ev_count <= ev_count + CNT_W'(1);
          if (full && !pop) overflow <= 1'b1;
        end
        if (push) begin
          mem_ts[wr_ptr[AW-1:0]]  <= ts;
          mem_idx[wr_ptr[AW-1:0]] <= seq;
          wr_ptr <= wr_ptr + (AW+1)'(1);
        end
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: doc/trig_event_monitor.md
# trig_event_monitor

Receiving end of the trigger interface: consumes the single-bit trigger produced by a trigger-sequence counter, detects each rising edge, and logs it as a timestamped event. Events are buffered in a small FIFO and drained by the detection/verification harness over a valid/ready handshake. The block sits beside the trigger source in the same clock domain and gives test infrastructure a cycle-accurate record of activations, with a sticky overflow flag when records are lost.

## Interface
Parameters:
- `TS_W`, 16 — timestamp counter width
- `CNT_W`, 8 — event sequence/count width
- `DEPTH`, 4 — FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  — clock; all logic on rising edge
- `rst`  in  1  — asynchronous, active-high reset; one clock
- `en`  in  1  — arm; edges are logged only while 1
- `clr`  in  1  — synchronous clear of FIFO, counts and overflow
- `trig_in`  in  1  — trigger level from the trigger source
- `ev_valid`  out  1  — FIFO head holds an event
- `ev_ready`  in  1  — consumer accepts the head
- `ev_ts`  out  TS_W  — timestamp of the head event
- `ev_idx`  out  CNT_W  — sequence number of the head event
- `ev_count`  out  CNT_W  — total edges detected while armed; saturating
- `overflow`  out  1  — sticky; an event was dropped
- `active`  out  1  — registered trigger level seen by the edge detector

## Operation
- Reset values: `ts`=0, `seq`=0, `trig_d`=0, FIFO empty, `ev_valid`=0, `ev_ts`=0, `ev_idx`=0, `ev_count`=0, `overflow`=0, `active`=0.
- Timestamp `ts`:
  - Free-running; increments every cycle and wraps modulo 2^TS_W.
  - Not affected by `clr` or `en`.
- Edge detect:
  - `trig_d` registers the detector input every cycle, regardless of `en`.
  - `edge = in & ~trig_d`.
  - `active` equals `trig_d`.
- On `edge & en & ~clr`:
  - `ev_count` increments and saturates at all-ones.
  - `seq` increments and wraps.
  - Push {`ts`, `seq`} into the FIFO, using the pre-increment values from that cycle.
- FIFO:
  - `ev_valid` = not empty.
  - `ev_ts`/`ev_idx` present the head combinationally from storage.
  - A pop occurs on `ev_valid & ev_ready`.
- Boundary cases:
  - **Full, push, no pop:** the event is dropped. `overflow` is set; `ev_count` and `seq` still increment.
  - **Full, push and pop in the same cycle:** both happen. No overflow.
  - **Empty, push:** the head appears the next cycle. No same-cycle bypass.
  - **`ev_ready` while empty:** ignored.
  - **`clr`:** empties the FIFO and zeroes `ev_count`, `seq` and `overflow`. It overrides a same-cycle push and pop. `trig_d` still updates, so a level held high across `clr` produces no event.
  - **`en` rising while the trigger is already high:** no event.
  - **`rst` mid-operation:** all state returns to reset values immediately. Partially drained events are lost.

## Timing
- Trigger sampled high at edge N (with `trig_d`=0) → push at edge N → `ev_valid`=1 after edge N.
- The logged `ev_ts` equals `ts` before edge N.
- Back-to-back edges need the trigger to toggle. The minimum event spacing is 2 cycles.
- Pop at edge M → next head (or `ev_valid`=0) visible after edge M.
- A consumer holding `ev_ready`=1 drains one event per cycle.
- `ev_valid` never deasserts without a pop, `clr` or `rst`. Head data is stable while `ev_valid & ~ev_ready`.

## Configuration
- `TRIG_SYNC_EN` defined:
  - `trig_in` passes through a 2-flop synchronizer (reset to 0) before the edge detector.
  - Detection latency grows by 2 cycles; the logged `ts` is the value at detection, not at the `trig_in` transition.
  - `active` reflects the synchronized level.
- `TRIG_SYNC_EN` undefined:
  - `trig_in` feeds the edge detector directly, with the latency above.

## Test plan
- **Single edge:** after `rst` release hold `en`=1 and `ev_ready`=0. Raise `trig_in` when `ts`=20, hold 3 cycles, drop. Expect exactly one event: `ev_valid`=1 the next cycle, `ev_ts`=20, `ev_idx`=0, `ev_count`=1.
- **Overflow, DEPTH=4:** `ev_ready`=0, 6 trigger pulses spaced 4 cycles. Expect 4 events held with `ev_idx` 0..3, `overflow`=1, `ev_count`=6. Drain gives idx 0,1,2,3, then `ev_valid`=0.
- **Full with simultaneous push/pop:** fill 4 entries. Pulse the trigger with `ev_ready`=1 on the same edge. Expect `overflow`=0, the FIFO still holds 4 entries, and the new entry has `ev_idx`=4.
- **Arm/clear:** raise the trigger with `en`=0, then set `en`=1 while it stays high; expect no event. Assert `clr` on the cycle of a new edge; expect an empty FIFO, `ev_count`=0 and no push.
- **Reset and wrap:** with TS_W=4, log an edge at `ts`=15 and the next at `ts`=3 (wrapped); expect `ev_ts` values 15 then 3. Assert `rst` while 2 events are pending; expect all outputs at reset values asynchronously.
- **With `TRIG_SYNC_EN`:** `trig_in` rises when `ts`=10. Expect `ev_ts`=12 and `ev_valid` 3 cycles after the rise.
